// File: rtl/gam_pattern_feeder.sv
// Tuple FIFO and LEARNING->RECALL phase sequencer feeding the GAM memory layer.
// Optional zero-vector/zero-class filter is enabled by defining GAM_ZERO_CHECK_EN.
module gam_pattern_feeder #(
  parameter int VECTOR_LEN = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VECTOR_LEN*8-1:0] in_vector,
  input  logic [31:0]             in_class,
  input  logic                    in_last,
  input  logic                    ready_wait,
  output logic [VECTOR_LEN*8-1:0] out_x,
  output logic [31:0]             out_c,
  output logic                    out_valid,
  output logic                    learning_done,
  output logic                    learning_recall,
  output logic [CNT_W-1:0]        pattern_count,
  output logic                    err_zero,
  output logic [2:0]              dbg_state
);

  localparam int VW = VECTOR_LEN * 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_BLANK = 3'd1,
    L_BUSY  = 3'd2,
    R_RUN   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t state, state_nx;

  // Handshake: a tuple transfers on any posedge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.
  logic [VW-1:0]    mem_vec [DEPTH];
  logic [31:0]      mem_cls [DEPTH];
  logic [DEPTH-1:0] mem_last;

  logic [AW-1:0] wr_ptr, rd_ptr, tail_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          push, wr_en, pop, issue;
  logic          zero_tuple, merge_last, head_last;
  logic          issued_last;

  assign fifo_empty = (count == '0);
  assign in_ready   = (count < CW'(DEPTH)) && (state != FINISH);
  assign push       = in_valid && in_ready;

`ifdef GAM_ZERO_CHECK_EN
  assign zero_tuple = (in_vector == '0) || (in_class == '0);
`else
  assign zero_tuple = 1'b0;
`endif

  assign wr_en      = push && !zero_tuple;
  assign tail_ptr   = wr_ptr - AW'(1);
  // A dropped tuple carrying last hands its flag to the newest stored entry.
  assign merge_last = push && zero_tuple && in_last && !fifo_empty;
  // If that newest entry is the one leaving this cycle, the flag goes with it.
  assign head_last  = mem_last[rd_ptr] | (merge_last && (rd_ptr == tail_ptr));

  assign learning_done   = (state == R_RUN) || (state == FINISH);
  assign learning_recall = (state == R_RUN);
  assign dbg_state       = state;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    issue    = 1'b0;
    case (state)
      L_IDLE: begin
        if (!fifo_empty && ready_wait) begin
          pop      = 1'b1;
          issue    = 1'b1;
          state_nx = L_BLANK;
        end
      end
      // The layer may need a cycle to drop READY after a strobe.
      L_BLANK: state_nx = L_BUSY;
      L_BUSY: begin
        if (ready_wait) begin
          state_nx = issued_last ? R_RUN : L_IDLE;
        end
      end
      R_RUN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_last) begin
            state_nx = FINISH;
          end
        end
      end
      FINISH:  state_nx = FINISH;
      default: state_nx = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= L_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      out_x         <= '0;
      out_c         <= '0;
      out_valid     <= 1'b0;
      pattern_count <= '0;
      issued_last   <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_x  <= mem_vec[rd_ptr];
        out_c  <= mem_cls[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (issue) begin
        issued_last <= head_last;
        if (pattern_count != '1) begin
          pattern_count <= pattern_count + CNT_W'(1);
        end
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_vec[wr_ptr]  <= in_vector;
      mem_cls[wr_ptr]  <= in_class;
      mem_last[wr_ptr] <= in_last;
    end
    if (merge_last) begin
      mem_last[tail_ptr] <= 1'b1;
    end
  end

`ifdef GAM_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_zero <= 1'b0;
    end else if (push && zero_tuple) begin
      err_zero <= 1'b1;
    end
  end
`else
  assign err_zero = 1'b0;
`endif

endmodule

// File: tb/tb_gam_pattern_feeder.sv
// Self-checking bench for gam_pattern_feeder: scoreboarded strobes plus
// per-scenario phase, backpressure, reset and zero-filter checks.
`timescale 1ns/1ps
module tb_gam_pattern_feeder;

  localparam int VECTOR_LEN = 16;
  localparam int DEPTH      = 8;
  localparam int CNT_W      = 16;
  localparam int VW         = VECTOR_LEN * 8;
  localparam int W          = 32 + VW;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [VW-1:0]     in_vector;
  logic [31:0]       in_class;
  logic              in_last;
  logic              ready_wait;
  logic [VW-1:0]     out_x;
  logic [31:0]       out_c;
  logic              out_valid;
  logic              learning_done;
  logic              learning_recall;
  logic [CNT_W-1:0]  pattern_count;
  logic              err_zero;
  logic [2:0]        dbg_state;

  logic man_rw;
  logic auto_rw;
  logic auto_mode;
  assign ready_wait = auto_mode ? auto_rw : man_rw;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  gam_pattern_feeder #(
    .VECTOR_LEN(VECTOR_LEN),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_vector(in_vector),
    .in_class(in_class),
    .in_last(in_last),
    .ready_wait(ready_wait),
    .out_x(out_x),
    .out_c(out_c),
    .out_valid(out_valid),
    .learning_done(learning_done),
    .learning_recall(learning_recall),
    .pattern_count(pattern_count),
    .err_zero(err_zero),
    .dbg_state(dbg_state)
  );

  // Scoreboard: every strobe must match the oldest outstanding expected tuple.
  initial begin : scoreboard
    logic [W-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected: got class=%0d, no tuple outstanding", out_c);
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_c, out_x} !== exp_v) begin
            errors++;
            $display("FAIL strobe_data: got class=%0d x=%h, expected class=%0d x=%h",
                     out_c, out_x, exp_v[W-1 -: 32], exp_v[VW-1:0]);
          end
        end
      end
    end
  end

  // Memory-layer model: WAIT for a few cycles after each strobe, else READY.
  initial begin : layer_model
    auto_rw = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        auto_rw = 1'b0;
        repeat (3) @(negedge clk);
        auto_rw = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    v[0] = 1'b1;
    return v;
  endfunction

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    reset     = 1'b1;
    auto_mode = 1'b0;
    man_rw    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Must be entered just after a posedge; returns just after the accepting posedge.
  task automatic push_tuple(input logic [VW-1:0] vec, input logic [31:0] cls,
                            input logic last, input bit exp_out);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_vector = vec;
    in_class  = cls;
    in_last   = last;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_accept: in_ready=%b after %0d cycles, required 1 (class %0d)",
               in_ready, guard, cls);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (exp_out) exp_q.push_back({cls, vec});
    end
  endtask

  task automatic wait_drain(input int bound);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < bound) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d tuples still outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_recall(input int bound);
    int g;
    g = 0;
    @(negedge clk);
    while (learning_recall !== 1'b1 && g < bound) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (learning_recall !== 1'b1) begin
      errors++;
      $display("FAIL recall_entry: learning_recall=%b, required 1", learning_recall);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, learning_done, learning_recall, err_zero} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: valid/done/recall/err=%b, required 0000",
               {out_valid, learning_done, learning_recall, err_zero});
    end
    checks++;
    if (out_x !== '0 || out_c !== 32'd0 || pattern_count !== '0) begin
      errors++;
      $display("FAIL reset_data: out_c=%0d count=%0d, required 0 0", out_c, pattern_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    next_drive();
  endtask

  task automatic test_learning();
    int g;
    do_reset();
    auto_mode = 1'b1;
    push_tuple(rand_vec(), 32'd1, 1'b0, 1'b1);
    push_tuple(rand_vec(), 32'd2, 1'b0, 1'b1);
    push_tuple(rand_vec(), 32'd3, 1'b1, 1'b1);
    g = 0;
    @(negedge clk);
    while (learning_done !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (learning_done !== 1'b1 || learning_recall !== 1'b1) begin
      errors++;
      $display("FAIL learn_phase_flip: done=%b recall=%b, required 1 1",
               learning_done, learning_recall);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL learn_order: %0d strobes missing when learning_done rose, required 0",
               exp_q.size());
    end
    checks++;
    if (pattern_count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL learn_count: pattern_count=%0d, required 3", pattern_count);
    end
    next_drive();
  endtask

  task automatic test_full();
    do_reset();
    man_rw = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_tuple(rand_vec(), 32'(16 + i), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    next_drive();
    fork
      begin
        push_tuple(rand_vec(), 32'(16 + DEPTH), 1'b0, 1'b1);
        push_tuple(rand_vec(), 32'(17 + DEPTH), 1'b1, 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: in_ready=%b in wait cycle %0d, required 0", in_ready, k);
          end
        end
        auto_mode = 1'b1;
      end
    join
    wait_drain(600);
    wait_recall(100);
    checks++;
    if (pattern_count !== CNT_W'(DEPTH + 2)) begin
      errors++;
      $display("FAIL full_count: pattern_count=%0d, required %0d", pattern_count, DEPTH + 2);
    end
    next_drive();
  endtask

  task automatic test_recall();
    do_reset();
    auto_mode = 1'b1;
    push_tuple(rand_vec(), 32'd256, 1'b1, 1'b1);
    wait_recall(100);
    checks++;
    if (pattern_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL single_learn_count: pattern_count=%0d, required 1", pattern_count);
    end
    next_drive();
    auto_mode = 1'b0;
    man_rw    = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          push_tuple(rand_vec(), 32'($urandom_range(1, 5000)), (i == 3), 1'b1);
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && g < 20) begin
          @(negedge clk);
          g++;
        end
        for (int k = 1; k < 4; k++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL recall_back_to_back: out_valid=%b at probe %0d, required 1",
                     out_valid, k);
          end
        end
      end
    join
    checks++;
    if ({learning_done, learning_recall, in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL finish_flags: done/recall/in_ready=%b, required 100",
               {learning_done, learning_recall, in_ready});
    end
    checks++;
    if (pattern_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL recall_count_frozen: pattern_count=%0d, required 1", pattern_count);
    end
    next_drive();
    in_valid = 1'b1;
    in_class = 32'd77;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL finish_ignores_input: in_ready=%b, required 0", in_ready);
      end
    end
    next_drive();
    in_valid = 1'b0;
    wait_drain(20);
    next_drive();
  endtask

  task automatic test_reset_mid_busy();
    int g;
    do_reset();
    push_tuple(rand_vec(), 32'd768, 1'b0, 1'b1);
    g = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    man_rw = 1'b0;
    next_drive();
    // These five are discarded by the reset below, so none may ever strobe.
    for (int i = 1; i <= 5; i++) push_tuple(rand_vec(), 32'(768 + i), 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd2 || pattern_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL busy_setup: state=%0d count=%0d, required 2 1", dbg_state, pattern_count);
    end
    next_drive();
    reset = 1'b1;
    next_drive();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_x !== '0 || out_c !== 32'd0 || out_valid !== 1'b0 || pattern_count !== '0 ||
        learning_done !== 1'b0 || learning_recall !== 1'b0 || err_zero !== 1'b0) begin
      errors++;
      $display("FAIL busy_reset_outputs: out_c=%0d valid=%b count=%0d done=%b, required all 0",
               out_c, out_valid, pattern_count, learning_done);
    end
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL busy_reset_state: in_ready=%b state=%0d, required 1 0", in_ready, dbg_state);
    end
    man_rw = 1'b1;
    next_drive();
    push_tuple(rand_vec(), 32'd938, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: out_valid=%b one cycle after push, required 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2: out_valid=%b two cycles after push, required 1", out_valid);
    end
    wait_drain(20);
    next_drive();
  endtask

  task automatic test_zero();
    bit          filt;
    logic [VW-1:0] zero_vec;
`ifdef GAM_ZERO_CHECK_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    zero_vec = '0;
    do_reset();
    auto_mode = 1'b1;
    push_tuple(rand_vec(), 32'd4, 1'b0, 1'b1);
    push_tuple(rand_vec(), 32'd0, 1'b0, !filt);
    push_tuple(rand_vec(), 32'd5, 1'b0, 1'b1);
    // Zero vector with last: when filtered, its last flag must move onto class 5.
    push_tuple(zero_vec, 32'd6, 1'b1, !filt);
    wait_drain(200);
    wait_recall(100);
    checks++;
    if (err_zero !== filt) begin
      errors++;
      $display("FAIL zero_err_flag: err_zero=%b, required %b", err_zero, filt);
    end
    checks++;
    if (pattern_count !== (filt ? CNT_W'(2) : CNT_W'(4))) begin
      errors++;
      $display("FAIL zero_count: pattern_count=%0d, required %0d", pattern_count, filt ? 2 : 4);
    end
    next_drive();
  endtask

  initial begin : main
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vector = '0;
    in_class  = '0;
    in_last   = 1'b0;
    man_rw    = 1'b1;
    auto_mode = 1'b0;
    test_reset();
    test_learning();
    test_full();
    test_recall();
    test_reset_mid_busy();
    test_zero();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d expected strobes never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
